// File: rtl/mem_access_ctrl.sv
// LC-3 memory port A sequencer: round-robin CPU/loader arbitration driving MAR/MDR/RAM-WE.
// Optional MEMCTRL_WRITE_PROTECT_EN rejects CPU writes below PROTECT_LIMIT with cpu_err.
module mem_access_ctrl #(
    parameter int unsigned WAIT_STATES = 1
`ifdef MEMCTRL_WRITE_PROTECT_EN
    , parameter logic [15:0] PROTECT_LIMIT = 16'h3000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [15:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_ready,
    output logic [15:0] ldr_rdata,
    input  logic [15:0] MDROut,
    output logic [15:0] bus_out,
    output logic        bus_en,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        selMDR,
    output logic        memWE,
    output logic        busy,
`ifdef MEMCTRL_WRITE_PROTECT_EN
    output logic        cpu_err,
`endif
    output logic        grant_ldr
);

    typedef enum logic [2:0] {IDLE, LD_MAR, LD_MDR, WRITE, WAIT, CAPTURE, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        last_ldr_reg, last_ldr_next;
    logic        owner_reg, owner_next;
    logic        we_reg, we_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic [15:0] cpu_rdata_reg, ldr_rdata_reg;
    logic [15:0] bus_out_reg;
    logic        bus_en_reg, ld_mar_reg, ld_mdr_reg, sel_mdr_reg, mem_we_reg;
    logic        cpu_ready_reg, ldr_ready_reg, busy_reg;
    logic        grant_ldr_now;
`ifdef MEMCTRL_WRITE_PROTECT_EN
    logic        err_reg, err_next, cpu_err_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        last_ldr_next = last_ldr_reg;
        owner_next    = owner_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
`ifdef MEMCTRL_WRITE_PROTECT_EN
        err_next      = err_reg;
`endif
        // Loader wins when it is alone, or on a tie when the CPU had the last grant.
        grant_ldr_now = ldr_req & (~cpu_req | ~last_ldr_reg);
        case (state_reg)
            IDLE: begin
                if (cpu_req | ldr_req) begin
                    owner_next    = grant_ldr_now;
                    last_ldr_next = grant_ldr_now;
                    we_next       = grant_ldr_now ? ldr_we    : cpu_we;
                    addr_next     = grant_ldr_now ? ldr_addr  : cpu_addr;
                    wdata_next    = grant_ldr_now ? ldr_wdata : cpu_wdata;
                    state_next    = LD_MAR;
`ifdef MEMCTRL_WRITE_PROTECT_EN
                    err_next = 1'b0;
                    if (!grant_ldr_now && cpu_we && (cpu_addr < PROTECT_LIMIT)) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
`endif
                end
            end
            LD_MAR: begin
                if (we_reg) begin
                    state_next = LD_MDR;
                end else begin
                    state_next = WAIT;
                    cnt_next   = WAIT_INIT;
                end
            end
            LD_MDR:  state_next = WRITE;
            WRITE:   state_next = DONE;
            WAIT: begin
                if (cnt_reg <= 4'd1) state_next = CAPTURE;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            last_ldr_reg  <= 1'b0;
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 16'h0000;
            wdata_reg     <= 16'h0000;
            cpu_rdata_reg <= 16'h0000;
            ldr_rdata_reg <= 16'h0000;
            bus_out_reg   <= 16'h0000;
            bus_en_reg    <= 1'b0;
            ld_mar_reg    <= 1'b0;
            ld_mdr_reg    <= 1'b0;
            sel_mdr_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            cpu_ready_reg <= 1'b0;
            ldr_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef MEMCTRL_WRITE_PROTECT_EN
            err_reg       <= 1'b0;
            cpu_err_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_ldr_reg  <= last_ldr_next;
            owner_reg     <= owner_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            bus_en_reg    <= (state_next == LD_MAR) || (state_next == LD_MDR);
            bus_out_reg   <= (state_next == LD_MAR) ? addr_next :
                             (state_next == LD_MDR) ? wdata_next : 16'h0000;
            ld_mar_reg    <= (state_next == LD_MAR);
            ld_mdr_reg    <= (state_next == LD_MDR) || (state_next == CAPTURE);
            sel_mdr_reg   <= (state_next == CAPTURE);
            mem_we_reg    <= (state_next == WRITE);
            cpu_ready_reg <= (state_next == DONE) && !owner_next;
            ldr_ready_reg <= (state_next == DONE) && owner_next;
            busy_reg      <= (state_next != IDLE);
`ifdef MEMCTRL_WRITE_PROTECT_EN
            err_reg       <= err_next;
            cpu_err_reg   <= (state_next == DONE) && err_next;
`endif
            if (state_reg == DONE && !we_reg) begin
                if (owner_reg) ldr_rdata_reg <= MDROut;
                else           cpu_rdata_reg <= MDROut;
            end
        end
    end

    assign bus_out   = bus_out_reg;
    assign bus_en    = bus_en_reg;
    assign ldMAR     = ld_mar_reg;
    assign ldMDR     = ld_mdr_reg;
    assign selMDR    = sel_mdr_reg;
    assign memWE     = mem_we_reg;
    assign cpu_ready = cpu_ready_reg;
    assign ldr_ready = ldr_ready_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign ldr_rdata = ldr_rdata_reg;
    assign busy      = busy_reg;
    assign grant_ldr = last_ldr_reg;
`ifdef MEMCTRL_WRITE_PROTECT_EN
    assign cpu_err   = cpu_err_reg;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: MAR/MDR/RAM model around the controller, table-driven
// single transactions plus tie, reset-abort and WAIT_STATES=3 sequences.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
    logic        cpu_ready, ldr_ready, bus_en, ldMAR, ldMDR, selMDR, memWE, busy, grant_ldr;
    logic [15:0] cpu_rdata, ldr_rdata, bus_out, mdr;
    logic [15:0] mar;

    mem_access_ctrl #(.WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ready(ldr_ready), .ldr_rdata(ldr_rdata),
        .MDROut(mdr), .bus_out(bus_out), .bus_en(bus_en),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR), .memWE(memWE),
        .busy(busy), .grant_ldr(grant_ldr)
    );

    // Second instance with a longer read wait; loader side is tied off.
    logic        c3_req = 0, c3_we = 0, tie1 = 0;
    logic [15:0] c3_addr = 0, c3_wdata = 0, tie16 = 0, mdr3 = 16'hC0DE;
    logic        c3_ready, l3_ready, bus_en3, ldMAR3, ldMDR3, selMDR3, memWE3, busy3, grant3;
    logic [15:0] c3_rdata, l3_rdata, bus_out3;

    mem_access_ctrl #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_ready(c3_ready), .cpu_rdata(c3_rdata),
        .ldr_req(tie1), .ldr_we(tie1), .ldr_addr(tie16), .ldr_wdata(tie16),
        .ldr_ready(l3_ready), .ldr_rdata(l3_rdata),
        .MDROut(mdr3), .bus_out(bus_out3), .bus_en(bus_en3),
        .ldMAR(ldMAR3), .ldMDR(ldMDR3), .selMDR(selMDR3), .memWE(memWE3),
        .busy(busy3), .grant_ldr(grant3)
    );

    // Datapath model: MAR, MDR with its input mux, and the RAM (initialised to addr^5555).
    logic [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (ldMAR) mar <= bus_out;
        if (ldMDR) mdr <= selMDR ? ram[mar] : bus_out;
        if (memWE) ram[mar] <= mdr;
    end

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_cpu = 16'h0000;
    logic [15:0] exp_ldr = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          ldr;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd;
    } vec_t;

    task automatic run_txn(input string tag, input vec_t v);
        int lat = 0, mar_c = 0, mdr_c = 0, we_c = 0, we_n = 0;
        bit viol = 0, bus_bad = 0;
        @(negedge clk);
        if (v.ldr) begin ldr_req = 1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata; end
        else       begin cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if ((32'(ldMAR) + 32'(ldMDR) + 32'(memWE)) > 1) viol = 1;
            if (v.ldr ? cpu_ready : ldr_ready) viol = 1;
            if (!bus_en && bus_out !== 16'h0000) bus_bad = 1;
            if (memWE) begin we_n++; we_c = c; end
            if (ldMAR && mar_c == 0) begin
                mar_c = c;
                if (!bus_en || bus_out !== v.addr) bus_bad = 1;
            end
            if (ldMDR && mdr_c == 0) begin
                mdr_c = c;
                if (v.we && (selMDR || !bus_en || bus_out !== v.wdata)) bus_bad = 1;
                if (!v.we && (!selMDR || bus_en)) bus_bad = 1;
            end
            if (v.ldr ? ldr_ready : cpu_ready) begin
                lat = c;
                cpu_req = 0; ldr_req = 0;
                break;
            end
            // Scramble the live request fields; the latched copy must be used.
            if (c == 2) begin
                cpu_addr = ~cpu_addr; cpu_wdata = ~cpu_wdata;
                ldr_addr = ~ldr_addr; ldr_wdata = ~ldr_wdata;
            end
        end
        check({tag, " latency"}, 32'(lat), v.we ? 32'd4 : 32'd4);
        check({tag, " ldMAR cycle"}, 32'(mar_c), 32'd1);
        check({tag, " ldMDR cycle"}, 32'(mdr_c), v.we ? 32'd2 : 32'd3);
        check({tag, " memWE count"}, 32'(we_n), v.we ? 32'd1 : 32'd0);
        check({tag, " memWE cycle"}, 32'(we_c), v.we ? 32'd3 : 32'd0);
        check({tag, " control exclusivity"}, 32'(viol), 32'd0);
        check({tag, " bus value"}, 32'(bus_bad), 32'd0);
        if (!v.we) begin
            if (v.ldr) exp_ldr = v.rd;
            else       exp_cpu = v.rd;
        end
        @(negedge clk);
        check({tag, " ready width"}, 32'({cpu_ready, ldr_ready}), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'(exp_cpu));
        check({tag, " ldr_rdata"}, 32'(ldr_rdata), 32'(exp_ldr));
        $display("[TB] %s %s %s addr=%h wdata=%h latency=%0d cpu_rdata=%h ldr_rdata=%h",
                 tag, v.ldr ? "ldr" : "cpu", v.we ? "W" : "R", v.addr, v.wdata, lat,
                 cpu_rdata, ldr_rdata);
    endtask

    vec_t vecs[10];

    initial begin
        int n, nc, nl, ready_seen, mdr_first, rdy_c, mar_c;
        bit snap;
        int order[4], rcyc[4], gl[4];
        logic [15:0] snap_cpu[4], snap_ldr[4];
        bit sel_at_mdr;

        for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'h5555;

        vecs[0] = '{0, 1, 16'h3000, 16'hBEEF, 16'h0000};
        vecs[1] = '{0, 0, 16'h3000, 16'h0000, 16'hBEEF};
        vecs[2] = '{1, 1, 16'h0200, 16'h1234, 16'h0000};
        vecs[3] = '{1, 0, 16'h0200, 16'h0000, 16'h1234};
        vecs[4] = '{0, 0, 16'h0200, 16'h0000, 16'h1234};
        vecs[5] = '{1, 0, 16'h3000, 16'h0000, 16'hBEEF};
        vecs[6] = '{0, 1, 16'hFFFF, 16'hA5A5, 16'h0000};
        vecs[7] = '{0, 0, 16'hFFFF, 16'h0000, 16'hA5A5};
        vecs[8] = '{1, 0, 16'h0000, 16'h0000, 16'h5555};
        vecs[9] = '{0, 0, 16'h1234, 16'h0000, 16'h4761};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset controls", 32'({ldMAR, ldMDR, selMDR, memWE, bus_en, busy, cpu_ready, ldr_ready}), 32'd0);
        check("reset bus_out", 32'(bus_out), 32'd0);
        check("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("reset ldr_rdata", 32'(ldr_rdata), 32'd0);
        check("reset grant_ldr", 32'(grant_ldr), 32'd0);
        reset = 1;

        // Tie from reset: loader first, then alternating, two each
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0020;
        n = 0; nc = 0; nl = 0; snap = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (snap) begin snap_cpu[n-1] = cpu_rdata; snap_ldr[n-1] = ldr_rdata; snap = 0; end
            if (n == 4 && !snap) break;
            if (cpu_ready && n < 4) begin
                order[n] = 0; rcyc[n] = c; gl[n] = 32'(grant_ldr); n++; snap = 1;
                nc++; if (nc == 2) cpu_req = 0;
            end
            if (ldr_ready && n < 4) begin
                order[n] = 1; rcyc[n] = c; gl[n] = 32'(grant_ldr); n++; snap = 1;
                nl++; if (nl == 2) ldr_req = 0;
            end
        end
        cpu_req = 0; ldr_req = 0;
        check("tie transaction count", 32'(n), 32'd4);
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("tie owner %0d", i), 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("tie grant_ldr %0d", i), 32'(gl[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("tie ready cycle %0d", i), 32'(rcyc[i]), 32'(4 + 5 * i));
                check($sformatf("tie cpu_rdata %0d", i), 32'(snap_cpu[i]), (i == 0) ? 32'h0 : 32'h5545);
                check($sformatf("tie ldr_rdata %0d", i), 32'(snap_ldr[i]), 32'h5575);
                $display("[TB] tie txn %0d owner=%s ready_cycle=%0d cpu_rdata=%h ldr_rdata=%h",
                         i, order[i] ? "ldr" : "cpu", rcyc[i], snap_cpu[i], snap_ldr[i]);
            end
        end
        exp_cpu = 16'h5545;
        exp_ldr = 16'h5575;

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Reset sampled while a read to 4000 sits in WAIT
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
        @(negedge clk);
        check("abort ldMAR in cycle 1", 32'(ldMAR), 32'd1);
        @(negedge clk);
        check("abort in WAIT", 32'({busy, bus_en, ldMAR, ldMDR, memWE}), 32'b10000);
        reset = 0; cpu_req = 0;
        @(negedge clk);
        check("abort controls", 32'({ldMAR, ldMDR, selMDR, memWE, bus_en, busy, cpu_ready, ldr_ready}), 32'd0);
        check("abort bus_out", 32'(bus_out), 32'd0);
        check("abort cpu_rdata cleared", 32'(cpu_rdata), 32'd0);
        reset = 1;
        ready_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ready || ldr_ready || busy) ready_seen++;
        end
        check("abort no ready", 32'(ready_seen), 32'd0);
        $display("[TB] abort read addr=4000 during WAIT");
        exp_cpu = 16'h0000;
        exp_ldr = 16'h0000;
        run_txn("post-abort", '{0, 0, 16'h4000, 16'h0000, 16'h1555});

        // WAIT_STATES=3 read
        @(negedge clk);
        c3_req = 1; c3_we = 0; c3_addr = 16'h0042;
        mdr_first = 0; rdy_c = 0; mar_c = 0; sel_at_mdr = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ldMAR3 && mar_c == 0) mar_c = c;
            if (ldMDR3 && mdr_first == 0) begin mdr_first = c; sel_at_mdr = selMDR3; end
            if (c3_ready) begin rdy_c = c; c3_req = 0; break; end
        end
        c3_req = 0;
        check("ws3 ldMAR cycle", 32'(mar_c), 32'd1);
        check("ws3 ldMDR cycle", 32'(mdr_first), 32'd5);
        check("ws3 selMDR at capture", 32'(sel_at_mdr), 32'd1);
        check("ws3 ready cycle", 32'(rdy_c), 32'd6);
        @(negedge clk);
        check("ws3 cpu_rdata", 32'(c3_rdata), 32'hC0DE);
        check("ws3 ready width", 32'(c3_ready), 32'd0);
        $display("[TB] ws3 cpu R addr=0042 ready_cycle=%0d cpu_rdata=%h", rdy_c, c3_rdata);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
